dm163_frame_tx: RTL

Parameterised serial frame transmitter for the DM163 colour-shield driver path. It shifts a whole frame of N_WORDS words, each WORD_W bits, out over s_clk/s_sda. Words arrive one at a time from an upstream frame buffer over a valid/ready handshake. After the last bit it pulses latch low for a programmable time and signals frame completion.

---
 rtl/dm163_frame_tx_if.sv | 26 ++
 rtl/dm163_frame_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm163_frame_tx_if.sv
// Word handshake between an upstream frame buffer and the DM163 frame transmitter.
// Latency: none (plain signal bundle).
// Backpressure: valid/ready; a word moves only in a cycle where both are high.
//
// Ports (via modports):
//   master - drives word_in/word_valid, observes word_ready (frame buffer side)
//   slave  - observes word_in/word_valid, drives word_ready (transmitter side)
interface dm163_frame_tx_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/dm163_frame_tx.sv
// Serial frame transmitter for the DM163 colour-shield driver: shifts N_WORDS words
//   of WORD_W bits out on s_clk/s_sda, then strobes latch low and pulses frame_done.
// Latency: frame_done in cycle 1 + N_WORDS*(1 + 2*HALF_PERIOD*WORD_W) + LATCH_CYCLES after start.
// Backpressure: word_ready only in LOAD; a missing word stalls with s_clk held low.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   start       - frame request, honoured only in IDLE
//   up          - word handshake (word_in / word_valid / word_ready), slave side
//   busy        - high in every state except IDLE
//   s_clk,s_sda - serial clock and data to the DM163 (sampled on s_clk rising edge)
//   latch       - active-low latch strobe, LATCH_CYCLES long after the last bit
//   frame_done  - one-cycle pulse at the end of each completed frame
//
// Build option: define DM163_TX_LSB_FIRST_EN to shift each word LSB first
// (default is MSB first). Timing and handshake are identical either way.
module dm163_frame_tx #(
    parameter int WORD_W       = 8,
    parameter int N_WORDS      = 24,
    parameter int HALF_PERIOD  = 3,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    dm163_frame_tx_if.slave       up,
    output logic                  busy,
    output logic                  s_clk,
    output logic                  s_sda,
    output logic                  latch,
    output logic                  frame_done
);

    // One timer serves both the s_clk half periods and the latch pulse.
    localparam int TMAX = (HALF_PERIOD > LATCH_CYCLES) ? HALF_PERIOD : LATCH_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(WORD_W + 1);
    localparam int NW   = $clog2(N_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_LATCH,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [TW-1:0]      tmr;
    logic [BW-1:0]      bit_cnt;
    logic [NW-1:0]      word_cnt;
    logic [WORD_W-1:0]  shreg;
    logic [WORD_W-1:0]  shreg_nxt;
    logic               sda_q;

    // Strobes from the FSM into the datapath.
    logic               clr_words;
    logic               load_word;
    logic               bit_done;
    logic               shift_bit;

    logic               half_end;
    logic               latch_end;
    logic               last_bit;
    logic               last_word;

    assign half_end  = (tmr == TW'(HALF_PERIOD - 1));
    assign latch_end = (tmr == TW'(LATCH_CYCLES - 1));
    assign last_bit  = (bit_cnt == BW'(1));
    // word_cnt counts accepted words, so it equals N_WORDS while the final word shifts.
    assign last_word = (word_cnt == NW'(N_WORDS));

`ifdef DM163_TX_LSB_FIRST_EN
    assign shreg_nxt = shreg >> 1;
`else
    assign shreg_nxt = shreg << 1;
`endif

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    //------------------------------------------------------------------
    // Next state and datapath strobes
    //------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        clr_words = 1'b0;
        load_word = 1'b0;
        bit_done  = 1'b0;
        shift_bit = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    clr_words = 1'b1;
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                if (up.word_valid) begin
                    load_word = 1'b1;
                    state_nxt = S_LOW;
                end
            end

            S_LOW: begin
                if (half_end) begin
                    state_nxt = S_HIGH;
                end
            end

            S_HIGH: begin
                if (half_end) begin
                    bit_done = 1'b1;
                    if (!last_bit) begin
                        shift_bit = 1'b1;
                        state_nxt = S_LOW;
                    end else if (last_word) begin
                        state_nxt = S_LATCH;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end

            S_LATCH: begin
                if (latch_end) begin
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here; a new frame needs IDLE.
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Phase timer: restarts on every state change, runs only in timed states.
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            tmr <= '0;
        end else if ((state == S_LOW) || (state == S_HIGH) || (state == S_LATCH)) begin
            tmr <= tmr + TW'(1);
        end
    end

    //------------------------------------------------------------------
    // Word/bit counters, shift register and serial data
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sda_q    <= 1'b0;
        end else begin
            if (clr_words) begin
                word_cnt <= '0;
            end

            if (load_word) begin
                shreg    <= up.word_in;
                bit_cnt  <= BW'(WORD_W);
                word_cnt <= word_cnt + NW'(1);
`ifdef DM163_TX_LSB_FIRST_EN
                sda_q    <= up.word_in[0];
`else
                sda_q    <= up.word_in[WORD_W-1];
`endif
            end

            if (bit_done) begin
                bit_cnt <= bit_cnt - BW'(1);
                if (shift_bit) begin
                    shreg <= shreg_nxt;
`ifdef DM163_TX_LSB_FIRST_EN
                    sda_q <= shreg_nxt[0];
`else
                    sda_q <= shreg_nxt[WORD_W-1];
`endif
                end else begin
                    // Word finished: park data low while loading or latching.
                    sda_q <= 1'b0;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // Outputs: decoded from the state register or straight from a flop,
    // so nothing on the input side reaches an output in the same cycle.
    //------------------------------------------------------------------
    assign up.word_ready = (state == S_LOAD);
    assign busy          = (state != S_IDLE);
    assign s_clk         = (state == S_HIGH);
    assign s_sda         = sda_q;
    assign latch         = (state != S_LATCH);
    assign frame_done    = (state == S_DONE);

endmodule
